// File: rtl/seq_adder_pkg.sv
// Shared types and size helpers for the sequential adder/subtractor.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-slice configuration still needs a one-bit index register.
  function automatic int calc_idx_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/seq_adder_if.sv
// Operand/result handshake bundle for seq_adder.
interface seq_adder_if #(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/seq_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells.
module chunk_adder
  import seq_adder_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[CHUNK];

endmodule

// File: rtl/seq_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed CHUNK bits per clock.
// Define SEQ_ADDER_SAT_EN to saturate the result on signed overflow.
module seq_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic        clk,
  input logic        rst_n,
  seq_adder_if.slave bus
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = calc_idx_w(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  state_t           state_r;
  state_t           state_nx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_slice_s;
  logic [WIDTH-1:0] sum_nx;
  logic [IDX_W-1:0] idx_r;
  logic             carry_r;
  logic             cout_r;
  logic             ovf_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [CHUNK-1:0] x_s;
  logic [CHUNK-1:0] y_s;
  logic [CHUNK-1:0] s_s;
  logic             co_s;
  logic             last_s;
  logic             ovf_s;

  assign last_s = (idx_r == LAST_IDX);
  // On the last slice s_s holds the result msb.
  assign ovf_s  = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (s_s[CHUNK-1] != a_r[WIDTH-1]);

`ifdef SEQ_ADDER_SAT_EN
  function automatic logic [WIDTH-1:0] sat_value(input logic neg);
    return {neg, {(WIDTH-1){~neg}}};
  endfunction

  assign sum_nx = (last_s && ovf_s) ? sat_value(a_r[WIDTH-1]) : sum_slice_s;
`else
  assign sum_nx = sum_slice_s;
`endif

  // Select the active operand slice and merge the fresh slice into the result.
  always_comb begin
    x_s         = '0;
    y_s         = '0;
    sum_slice_s = sum_r;
    for (int k = 0; k < NCHUNK; k++) begin
      x_s = (idx_r == IDX_W'(k)) ? a_r[k*CHUNK +: CHUNK] : x_s;
      y_s = (idx_r == IDX_W'(k)) ? b_r[k*CHUNK +: CHUNK] : y_s;
      sum_slice_s[k*CHUNK +: CHUNK] = (idx_r == IDX_W'(k)) ? s_s : sum_r[k*CHUNK +: CHUNK];
    end
  end

  chunk_adder #(
    .CHUNK(CHUNK)
  ) u_chunk_adder (
    .x (x_s),
    .y (y_s),
    .ci(carry_r),
    .s (s_s),
    .co(co_s)
  );

  // Next-state decode.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE:    state_nx = (bus.in_valid && in_ready_r) ? RUN : IDLE;
      RUN:     state_nx = last_s ? DONE : RUN;
      DONE:    state_nx = bus.out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Operand capture, per-slice accumulation and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      idx_r       <= '0;
      carry_r     <= 1'b0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_nx == IDLE);
      out_valid_r <= (state_nx == DONE);
      case (state_r)
        IDLE: begin
          idx_r <= '0;
          if (bus.in_valid && in_ready_r) begin
            a_r     <= bus.a;
            b_r     <= bus.sub ? ~bus.b : bus.b;
            carry_r <= bus.cin ^ bus.sub;
          end
        end
        RUN: begin
          sum_r   <= sum_nx;
          carry_r <= co_s;
          idx_r   <= last_s ? '0 : idx_r + IDX_W'(1);
          if (last_s) begin
            cout_r <= co_s;
            ovf_r  <= ovf_s;
          end
        end
        DONE: begin
          idx_r <= '0;
        end
        default: begin
          idx_r <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_seq_adder.sv
// Scoreboard bench for seq_adder in 16/4, 8/8 and 8/1 configurations.
module tb_seq_adder;

  typedef struct {
    longint sum;
    bit     cout;
    bit     ovf;
    int     acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ordy_mode = 2;
  int   nch[3] = '{4, 1, 8};
  exp_t q[3][$];
  bit   seen[3];
  bit   idle_chk[3];
  bit   ov[3];
  bit   ordy[3];
  bit   ir[3];
  bit   co[3];
  bit   of[3];
  longint sm[3];
  exp_t me;

  seq_adder_if #(.WIDTH(16)) if0 ();
  seq_adder_if #(.WIDTH(8))  if1 ();
  seq_adder_if #(.WIDTH(8))  if2 ();

  seq_adder #(.WIDTH(16), .CHUNK(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  seq_adder #(.WIDTH(8),  .CHUNK(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  seq_adder #(.WIDTH(8),  .CHUNK(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on the operands as unsigned and signed numbers.
  function automatic exp_t model(input int w, input longint a, input longint b, input bit s, input bit c);
    exp_t   e;
    longint lim, half, ci, sa, sb, ur, sr;
    lim  = 64'sd1 <<< w;
    half = lim / 64'sd2;
    ci   = c ? 64'sd1 : 64'sd0;
    sa   = (a >= half) ? a - lim : a;
    sb   = (b >= half) ? b - lim : b;
    if (s) begin
      ur     = a - b - ci;
      sr     = sa - sb - ci;
      e.cout = (ur >= 64'sd0);
    end else begin
      ur     = a + b + ci;
      sr     = sa + sb + ci;
      e.cout = (ur >= lim);
    end
    e.sum = ur & (lim - 64'sd1);
    e.ovf = (sr >= half) || (sr < -half);
`ifdef SEQ_ADDER_SAT_EN
    if (e.ovf) e.sum = (sa < 64'sd0) ? half : half - 64'sd1;
`endif
    e.acc = 0;
    return e;
  endfunction

  task automatic cmp(input string nm, input int dut, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h required %0h (cycle %0d)", nm, dut, act, expv, cyc);
    end
  endtask

  task automatic chk_reset(input string nm);
    cmp({nm, "_out_valid"}, 0, longint'(if0.out_valid), 64'sd0);
    cmp({nm, "_in_ready"},  0, longint'(if0.in_ready),  64'sd1);
    cmp({nm, "_sum"},       0, longint'(if0.sum),       64'sd0);
    cmp({nm, "_cout"},      0, longint'(if0.cout),      64'sd0);
    cmp({nm, "_ovf"},       0, longint'(if0.ovf),       64'sd0);
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue0(input logic [15:0] a, input logic [15:0] b, input bit s, input bit c);
    int   t = 0;
    exp_t e;
    if0.a = a; if0.b = b; if0.sub = s; if0.cin = c; if0.in_valid = 1'b1;
    while (!if0.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!if0.in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout dut0: in_ready=0 required 1");
    end else begin
      e = model(16, longint'(a), longint'(b), s, c);
      e.acc = cyc + 1;
      q[0].push_back(e);
    end
    @(negedge clk);
    if0.in_valid = 1'b0;
    if0.a = 16'($urandom); if0.b = 16'($urandom);
    if0.sub = 1'($urandom); if0.cin = 1'($urandom);
  endtask

  task automatic issue_small(input logic [7:0] a, input logic [7:0] b, input bit s, input bit c);
    int   t = 0;
    exp_t e;
    if1.a = a; if1.b = b; if1.sub = s; if1.cin = c; if1.in_valid = 1'b1;
    if2.a = a; if2.b = b; if2.sub = s; if2.cin = c; if2.in_valid = 1'b1;
    while (!(if1.in_ready && if2.in_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!(if1.in_ready && if2.in_ready)) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout dut1/2: in_ready=%0b/%0b required 1/1", if1.in_ready, if2.in_ready);
    end else begin
      e = model(8, longint'(a), longint'(b), s, c);
      e.acc = cyc + 1;
      q[1].push_back(e);
      q[2].push_back(e);
    end
    @(negedge clk);
    if1.in_valid = 1'b0; if2.in_valid = 1'b0;
    if1.a = 8'($urandom); if2.b = 8'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if ((q[0].size() + q[1].size() + q[2].size()) != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d/%0d/%0d results outstanding, required 0",
               q[0].size(), q[1].size(), q[2].size());
      for (int i = 0; i < 3; i++) q[i].delete();
    end
  endtask

  // Consumer back-pressure.
  initial forever begin
    @(negedge clk);
    if0.out_ready = (ordy_mode == 1) ? 1'b0 : (ordy_mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
    if1.out_ready = (ordy_mode == 1) ? 1'b0 : (ordy_mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
    if2.out_ready = (ordy_mode == 1) ? 1'b0 : (ordy_mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: compares every presented result against the head of its queue.
  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      ov   = '{if0.out_valid, if1.out_valid, if2.out_valid};
      ordy = '{if0.out_ready, if1.out_ready, if2.out_ready};
      ir   = '{if0.in_ready,  if1.in_ready,  if2.in_ready};
      co   = '{if0.cout,      if1.cout,      if2.cout};
      of   = '{if0.ovf,       if1.ovf,       if2.ovf};
      sm[0] = longint'(if0.sum); sm[1] = longint'(if1.sum); sm[2] = longint'(if2.sum);
      for (int i = 0; i < 3; i++) begin
        if (idle_chk[i]) begin
          cmp("in_ready_after_handshake", i, longint'(ir[i]), 64'sd1);
          idle_chk[i] = 1'b0;
        end
        if (ov[i]) begin
          if (q[i].size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_valid dut%0d: out_valid=1 required 0", i);
          end else begin
            me = q[i][0];
            if (!seen[i]) begin
              cmp("latency", i, longint'(cyc - me.acc), longint'(nch[i]));
              seen[i] = 1'b1;
            end
            cmp("sum",  i, sm[i], me.sum);
            cmp("cout", i, longint'(co[i]), longint'(me.cout));
            cmp("ovf",  i, longint'(of[i]), longint'(me.ovf));
            cmp("in_ready_in_done", i, longint'(ir[i]), 64'sd0);
            if (ordy[i]) begin
              void'(q[i].pop_front());
              seen[i] = 1'b0;
              idle_chk[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst_n = 1'b0;
    if0.in_valid = 1'b0; if0.a = 16'h0; if0.b = 16'h0; if0.sub = 1'b0; if0.cin = 1'b0;
    if1.in_valid = 1'b0; if1.a = 8'h0;  if1.b = 8'h0;  if1.sub = 1'b0; if1.cin = 1'b0;
    if2.in_valid = 1'b0; if2.a = 8'h0;  if2.b = 8'h0;  if2.sub = 1'b0; if2.cin = 1'b0;
    @(negedge clk);
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    issue0(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    issue0(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    issue0(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    issue0(16'h0005, 16'h0007, 1'b1, 1'b0);
    issue0(16'h8000, 16'h0001, 1'b1, 1'b0);
    ordy_mode = 0;
    for (int i = 0; i < 30; i++) issue0(pick16(), pick16(), 1'($urandom), 1'($urandom));
    drain();

    // Result held while the consumer stalls, then a back-to-back op.
    ordy_mode = 1;
    issue0(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    t = 0;
    while (!if0.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    ordy_mode = 2;
    issue0(16'hA5A5, 16'h5A5A, 1'b0, 1'b1);
    drain();

    // Reset in the middle of an operation discards it.
    issue0(16'h4321, 16'h1111, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      seen[i] = 1'b0;
      idle_chk[i] = 1'b0;
    end
    #1;
    chk_reset("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk_reset("after_reset");
    issue0(16'h0001, 16'h0001, 1'b0, 1'b0);
    drain();

    // Single-slice and bit-serial configurations.
    ordy_mode = 0;
    issue_small(8'hAA, 8'h55, 1'b0, 1'b1);
    drain();
    issue_small(8'h80, 8'h01, 1'b1, 1'b0);
    drain();
    for (int i = 0; i < 12; i++) begin
      issue_small(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
